// File: rtl/uart_rx_sequencer.sv
// rtl/uart_rx_sequencer.sv - oversampled UART receive sequencer with valid/ready character output
module uart_rx_sequencer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic                 shift_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_n;
    logic [SW-1:0]        sample_cnt, sample_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_valid_n, shift_en_n, frame_err_n, overrun_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            shift_en   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            sample_cnt <= sample_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_reg_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            shift_en   <= shift_en_n;
            frame_err  <= frame_err_n;
            overrun    <= overrun_n;
        end
    end

    always_comb begin
        state_n      = state;
        sample_cnt_n = sample_cnt;
        bit_cnt_n    = bit_cnt;
        shift_reg_n  = shift_reg;
        rx_data_n    = rx_data;
        rx_valid_n   = rx_valid;
        shift_en_n   = 1'b0;
        frame_err_n  = 1'b0;
        overrun_n    = 1'b0;

        // A load in the same cycle overrides this clear further down.
        if (rx_valid && rx_ready) begin
            rx_valid_n = 1'b0;
        end

        if (!rx_en) begin
            state_n = S_IDLE;
        end else if (sample_tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_in) begin
                        state_n      = S_START;
                        sample_cnt_n = '0;
                    end
                end
                S_START: begin
                    if (sample_cnt == HALF_LAST) begin
                        if (!rx_in) begin
                            state_n      = S_DATA;
                            sample_cnt_n = '0;
                            bit_cnt_n    = '0;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    sample_cnt_n = sample_cnt + 1'b1;
                    if (sample_cnt == FULL_LAST) begin
                        shift_reg_n = {rx_in, shift_reg[DATA_BITS-1:1]};
                        shift_en_n  = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_n = S_STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    sample_cnt_n = sample_cnt + 1'b1;
                    if (sample_cnt == FULL_LAST) begin
                        if (rx_in) begin
                            state_n = S_IDLE;
                            if (!rx_valid || rx_ready) begin
                                rx_data_n  = shift_reg;
                                rx_valid_n = 1'b1;
                            end else begin
                                overrun_n = 1'b1;
                            end
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_in) begin
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb/tb_uart_rx_sequencer.sv - randomized self-checking bench for uart_rx_sequencer
module tb_uart_rx_sequencer;

    localparam int OS = 16;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic       shift_en, rx_valid, frame_err, overrun, busy;
    logic [7:0] rx_data;

    int checks = 0;
    int failures = 0;
    int tdiv = 1;
    int divcnt = 0;
    bit rnd_ready = 1'b0;
    int n_shift = 0, n_fe = 0, n_ov = 0, n_vcyc = 0;

    uart_rx_sequencer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .sample_tick(sample_tick), .rx_in(rx_in),
        .shift_en(shift_en), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        sample_tick = (divcnt == 0);
        divcnt = (divcnt + 1 >= tdiv) ? 0 : divcnt + 1;
    end

    // Reference: the receiver samples the line at fixed tick offsets from the first low tick.
    logic       m_busy = 0, m_brk = 0, m_valid = 0, m_shift = 0, m_fe = 0, m_ov = 0;
    logic [7:0] m_data = 0, m_acc = 0;
    int         m_s = 0, m_tk = 0;

    always @(posedge clk or posedge rst) begin
        int rel, k;
        bit stop_ok;
        if (rst) begin
            m_busy = 0; m_brk = 0; m_valid = 0; m_shift = 0; m_fe = 0; m_ov = 0;
            m_data = 0; m_acc = 0;
        end else begin
            m_shift = 0; m_fe = 0; m_ov = 0; stop_ok = 0;
            if (sample_tick) m_tk++;
            if (!rx_en) begin
                m_busy = 0; m_brk = 0;
            end else if (sample_tick) begin
                if (!m_busy) begin
                    if (!rx_in) begin m_busy = 1; m_s = m_tk; end
                end else if (m_brk) begin
                    if (rx_in) begin m_busy = 0; m_brk = 0; end
                end else begin
                    rel = m_tk - m_s;
                    if (rel == OS / 2) begin
                        if (rx_in) m_busy = 0;
                    end else if (rel > OS / 2 && (rel - OS / 2) % OS == 0) begin
                        k = (rel - OS / 2) / OS;
                        if (k <= DB) begin
                            m_shift = 1;
                            m_acc[k-1] = rx_in;
                        end else if (rx_in) begin
                            stop_ok = 1; m_busy = 0;
                        end else begin
                            m_fe = 1; m_brk = 1;
                        end
                    end
                end
            end
            if (stop_ok && m_valid && !rx_ready) m_ov = 1;
            else if (stop_ok) begin m_valid = 1; m_data = m_acc; end
            else if (m_valid && rx_ready) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({shift_en, rx_valid, rx_data, frame_err, overrun, busy} !==
            {m_shift, m_valid, m_data, m_fe, m_ov, m_busy}) begin
            failures++;
            $display("FAIL cycle_compare t=%0t dut{sh,v,data,fe,ov,busy}=%b required=%b", $time,
                     {shift_en, rx_valid, rx_data, frame_err, overrun, busy},
                     {m_shift, m_valid, m_data, m_fe, m_ov, m_busy});
        end
        if (shift_en) n_shift++;
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        if (rx_valid) n_vcyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clr();
        n_shift = 0; n_fe = 0; n_ov = 0; n_vcyc = 0;
    endtask

    task automatic tick(input logic v);
        bit got = 0;
        rx_in = v;
        if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
        for (int n = 0; n < 64 && !got; n++) begin
            @(posedge clk);
            if (sample_tick) got = 1;
        end
        #1;
        chk("tick_timeout", int'(got), 1);
    endtask

    task automatic ticks(input logic v, input int n);
        repeat (n) tick(v);
    endtask

    task automatic frame(input logic [7:0] d, input int stop_low, input bit ready_pulse);
        ticks(1'b0, OS);
        for (int i = 0; i < DB; i++) ticks(d[i], OS);
        if (stop_low > 0) begin
            ticks(1'b0, stop_low);
            ticks(1'b1, OS);
        end else begin
            for (int j = 0; j < OS; j++) begin
                if (ready_pulse) rx_ready = (j == OS / 2);
                tick(1'b1);
            end
            if (ready_pulse) rx_ready = 1'b0;
        end
        ticks(1'b1, 4);
    endtask

    initial begin
        logic [7:0] b77;
        b77 = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", rx_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_data", rx_data, 0);
        rst = 1'b0;
        ticks(1'b1, 4);

        rx_ready = 1'b1; clr();
        frame(8'hA5, 0, 0);
        chk("t1_shift_pulses", n_shift, 8);
        chk("t1_data", rx_data, 8'hA5);
        chk("t1_valid_cycles", n_vcyc, 1);
        chk("t1_flags", n_fe + n_ov, 0);

        clr();
        ticks(1'b0, 5);
        ticks(1'b1, 3);
        chk("t2_busy_before_check", busy, 1);
        tick(1'b1);
        chk("t2_busy_after_check", busy, 0);
        chk("t2_no_shift", n_shift, 0);
        chk("t2_no_valid", n_vcyc, 0);

        clr();
        frame(8'h3C, 40, 0);
        chk("t3_frame_err", n_fe, 1);
        chk("t3_no_valid", n_vcyc, 0);
        chk("t3_busy_after_break", busy, 0);
        frame(8'h55, 0, 0);
        chk("t3_next_data", rx_data, 8'h55);

        rx_ready = 1'b0; clr();
        frame(8'h11, 0, 0);
        frame(8'h22, 0, 0);
        chk("t4_held_data", rx_data, 8'h11);
        chk("t4_held_valid", rx_valid, 1);
        chk("t4_overrun", n_ov, 1);
        rx_ready = 1'b1;
        ticks(1'b1, 3);
        chk("t4_drained", rx_valid, 0);
        chk("t4_not_delivered", rx_data, 8'h11);

        rx_ready = 1'b0; clr();
        frame(8'h11, 0, 0);
        frame(8'h22, 0, 1);
        chk("t5_data", rx_data, 8'h22);
        chk("t5_valid", rx_valid, 1);
        chk("t5_no_overrun", n_ov, 0);
        rx_ready = 1'b1;
        ticks(1'b1, 3);

        tdiv = 4; clr();
        ticks(1'b0, OS);
        for (int i = 0; i < 3; i++) ticks(b77[i], OS);
        ticks(b77[3], 5);
        rx_en = 1'b0;
        @(posedge clk); #1;
        chk("t6_en_busy", busy, 0);
        rx_en = 1'b1;
        ticks(1'b1, 2 * OS);
        chk("t6_en_shifts", n_shift, 3);
        chk("t6_en_flags", n_fe + n_ov + n_vcyc, 0);

        rx_ready = 1'b0;
        frame(8'h5A, 0, 0);
        chk("t6_pending", rx_valid, 1);
        ticks(1'b0, OS);
        for (int i = 0; i < 4; i++) ticks(b77[i], OS);
        ticks(b77[4], 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", rx_valid, 0);
        chk("t6_rst_data", rx_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ticks(1'b1, 4);
        rx_ready = 1'b1;
        frame(8'h81, 0, 0);
        chk("t6_after_rst_data", rx_data, 8'h81);

        rnd_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            int r;
            tdiv = $urandom_range(1, 3);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                ticks(1'b0, $urandom_range(1, 7));
                ticks(1'b1, 10);
            end else begin
                frame(8'($urandom), (r == 1) ? $urandom_range(9, 30) : 0, 0);
            end
            ticks(1'b1, $urandom_range(1, 6));
        end
        rnd_ready = 1'b0;
        rx_ready = 1'b1;
        ticks(1'b1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
